ddr_clk_out: RTL and testbench



---
 rtl/ddr_clk_out.sv | 82 ++++++++
 tb/tb_ddr_clk_out.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ddr_clk_out.sv
// ============================================================================
// ddr_clk_out
// ----------------------------------------------------------------------------
// Single-bit double-data-rate output register for the pad boundary. o_Q shows
// the rising-edge capture while i_Clk is high and the falling-edge capture
// while i_Clk is low. The flash controller uses it with D0=0 / D1=1 to forward
// an inverted, gateable copy of i_Clk onto o_Flash_Clk.
//
// Parameters
//   INIT           reset value of o_Q and of every internal flop
//   DDR_ALIGNMENT  "NONE" : D0 sampled on rise, D1 sampled on fall
//                  "C0"   : D0 and D1 both sampled on rise (D1 staged)
//                  "C1"   : D0 and D1 both sampled on fall (D0 staged)
//                  any other string behaves as "NONE"
//
// Ports
//   i_Clk   in  1  sole clock; the falling-edge domain is ~i_Clk
//   i_nRst  in  1  asynchronous, active-low reset
//   i_CE    in  1  clock enable; when 0 every capture flop holds
//   i_D0    in  1  data shown on o_Q during the high phase of i_Clk
//   i_D1    in  1  data shown on o_Q during the low phase of i_Clk
//   o_Q     out 1  DDR output
// ============================================================================
module ddr_clk_out #(
    parameter logic  INIT          = 1'b0,
    parameter string DDR_ALIGNMENT = "NONE"
) (
    input  logic i_Clk,
    input  logic i_nRst,
    input  logic i_CE,
    input  logic i_D0,
    input  logic i_D1,
    output logic o_Q
);

    // Alignment decoded once at elaboration; unknown strings fall to NONE.
    localparam int ALIGN_NONE = 0;
    localparam int ALIGN_C0   = 1;
    localparam int ALIGN_C1   = 2;
    localparam int ALIGN      = (DDR_ALIGNMENT == "C0") ? ALIGN_C0 :
                                (DDR_ALIGNMENT == "C1") ? ALIGN_C1 :
                                                          ALIGN_NONE;

    logic rPos;
    logic rNeg;
    logic rD1s;
    logic rD0s;

    // Rising-edge domain. rPos is the high-phase output bit. In C1 mode it
    // takes the D0 that was staged on the previous fall, so both bits of a
    // pair come from the same falling-edge sample. rD1s stages D1 for C0
    // mode; it is harmless in the other modes because nothing reads it.
    always_ff @(posedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            rPos <= INIT;
            rD1s <= INIT;
        end else if (i_CE) begin
            rPos <= (ALIGN == ALIGN_C1) ? rD0s : i_D0;
            rD1s <= i_D1;
        end
    end

    // Falling-edge domain. rNeg is the low-phase output bit. In C0 mode it
    // takes the D1 staged on the preceding rise, so a late change of i_D1
    // between rise and fall does not reach the pad. rD0s stages D0 for C1.
    always_ff @(negedge i_Clk or negedge i_nRst) begin
        if (!i_nRst) begin
            rNeg <= INIT;
            rD0s <= INIT;
        end else if (i_CE) begin
            rNeg <= (ALIGN == ALIGN_C0) ? rD1s : i_D1;
            rD0s <= i_D0;
        end
    end

    // Output mux steered by the clock itself: each capture appears on o_Q in
    // the same half-cycle as the edge that captured it.
    always_comb begin
        o_Q = i_Clk ? rPos : rNeg;
    end

endmodule

// File: tb/tb_ddr_clk_out.sv
// ============================================================================
// tb_ddr_clk_out
// ----------------------------------------------------------------------------
// Drives four ddr_clk_out instances in parallel from shared stimulus:
//   dut0 : NONE, INIT=0     dut1 : NONE, INIT=1
//   dut2 : C0,   INIT=0     dut3 : C1,   INIT=0
// Stimulus pushes hand-computed expected o_Q values into a scoreboard queue,
// tagged with the half-cycle they belong to; a monitor process samples o_Q in
// the middle of each half-cycle and pops/compares the matching entries.
// ============================================================================
module tb_ddr_clk_out;

    bit   tbClk = 1'b0;
    logic nRst;
    logic ce;
    logic d0;
    logic d1;
    logic oQ [4];

    typedef struct {
        int    tag;
        int    dut;
        logic  val;
        string name;
    } expEntry;

    expEntry sb [$];
    int      halfCount   = 0;
    int      vecApplied  = 0;
    int      miscompares = 0;

    ddr_clk_out #(.INIT(1'b0), .DDR_ALIGNMENT("NONE")) dut0 (
        .i_Clk(tbClk), .i_nRst(nRst), .i_CE(ce), .i_D0(d0), .i_D1(d1), .o_Q(oQ[0]));
    ddr_clk_out #(.INIT(1'b1), .DDR_ALIGNMENT("NONE")) dut1 (
        .i_Clk(tbClk), .i_nRst(nRst), .i_CE(ce), .i_D0(d0), .i_D1(d1), .o_Q(oQ[1]));
    ddr_clk_out #(.INIT(1'b0), .DDR_ALIGNMENT("C0")) dut2 (
        .i_Clk(tbClk), .i_nRst(nRst), .i_CE(ce), .i_D0(d0), .i_D1(d1), .o_Q(oQ[2]));
    ddr_clk_out #(.INIT(1'b0), .DDR_ALIGNMENT("C1")) dut3 (
        .i_Clk(tbClk), .i_nRst(nRst), .i_CE(ce), .i_D0(d0), .i_D1(d1), .o_Q(oQ[3]));

    // Free-running clock, period 10.
    initial begin
        forever #5 tbClk = ~tbClk;
    end

    // Compare one scoreboard entry against the sampled output.
    task automatic checkOutput(input expEntry e);
        vecApplied++;
        if (oQ[e.dut] !== e.val) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d half%0d: o_Q=%b expected %b",
                     e.name, e.dut, e.tag, oQ[e.dut], e.val);
        end
    endtask

    // Monitor: count half-cycles, sample 3 time units after each edge and
    // consume every entry due for this half-cycle.
    initial begin
        expEntry e;
        forever begin
            @(tbClk);
            halfCount++;
            #3;
            while (sb.size() > 0 && sb[0].tag <= halfCount) begin
                e = sb.pop_front();
                if (e.tag < halfCount) begin
                    vecApplied++;
                    miscompares++;
                    $display("[TB] FAIL %s dut%0d: stale entry for half%0d seen at half%0d",
                             e.name, e.dut, e.tag, halfCount);
                end else begin
                    checkOutput(e);
                end
            end
        end
    end

    // Push expectations for all four instances; ex is {dut3,dut2,dut1,dut0}.
    task automatic pushExpect(input int tag, input logic [3:0] ex, input string name);
        for (int i = 0; i < 4; i++) begin
            expEntry e;
            e.tag  = tag;
            e.dut  = i;
            e.val  = ex[i];
            e.name = name;
            sb.push_back(e);
        end
    endtask

    // One half-cycle of stimulus: 1 unit after an edge, drive the inputs that
    // the next edge will capture and record what o_Q must show after it.
    task automatic applyStimulus(input logic nr, input logic c, input logic a,
                                 input logic b, input logic [3:0] ex,
                                 input bit chk, input string name);
        @(tbClk);
        #1;
        nRst = nr;
        ce   = c;
        d0   = a;
        d1   = b;
        if (chk) pushExpect(halfCount + 1, ex, name);
    endtask

    initial begin
        int drain;
        nRst = 1'b0;
        ce   = 1'b0;
        d0   = 1'b0;
        d1   = 1'b0;

        // Reset held with the clock running: every instance sits at INIT.
        for (int i = 0; i < 4; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, "reset_hold");

        // NONE clock forwarding D0=0/D1=1; staging flops still at INIT for
        // the first half-cycle after release.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b1011, 1'b1, "fwd_first_fall");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, "fwd_rise");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b1, "fwd_fall");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'b0000, 1'b1, "fwd_rise2");

        // D1=0 before fall, D0=1 before rise; then D1 changed after the rise
        // (C0 must still show the staged 0 in that low phase).
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0100, 1'b1, "chg_fall_d1_0");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, "chg_rise_d0_1");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, "c0_staged_d1");

        // Capture D0=1/D1=1, then hold with CE low for three full cycles
        // while the data inputs go to 0.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, "cap11_rise");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, "cap11_fall");
        for (int i = 0; i < 6; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 1'b1, "ce_hold");

        // C1 mirror: D0 staged at the fall beats a later change before rise.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, "c1_held_stage");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, "c1_fall_d0_1");
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 1'b1, "c1_staged_d0");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b1, "set11_fall");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b1, "set11_rise");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, "pre_async");

        // Mid-phase asynchronous reset while o_Q is 1: visible immediately.
        @(tbClk);
        #2;
        nRst = 1'b0;
        pushExpect(halfCount, 4'b0010, "async_reset");

        // Stay in reset one more half, release, first capture on next edge.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, "reset_again");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0111, 1'b1, "post_rel_rise");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, "post_rel_fall");
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b1111, 1'b1, "post_rel_rise2");

        // Let the monitor drain, bounded by a fixed number of half-cycles.
        drain = 0;
        while (sb.size() > 0 && drain < 8) begin
            @(tbClk);
            drain++;
        end
        #4;
        if (sb.size() > 0) begin
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
            miscompares += sb.size();
            vecApplied  += sb.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecApplied, miscompares);
        $finish;
    end

endmodule
